// File: rtl/rsfq_clocked_gate_array.sv
// Cycle-based emulator of an array of clocked two-input RSFQ cells (XNOR/XOR/AND/OR).
// Pulses are toggle-encoded; critical-timing windows are counted in fabric cycles.
module rsfq_clocked_gate_array #(
  parameter int CHANNELS     = 4,
  parameter int MODE         = 0,
  parameter int DELAY        = 4,
  parameter int CT_CLK_DATA  = 2,
  parameter int CT_CLK_CLK   = 8,
  parameter int CT_DATA_CLK  = 3,
  parameter int CT_DATA_DATA = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] a_tgl,
  input  logic [CHANNELS-1:0] b_tgl,
  input  logic [CHANNELS-1:0] sfq_clk_tgl,
  output logic [CHANNELS-1:0] q_tgl,
  output logic [CHANNELS-1:0] err,
  output logic                err_any
);

  localparam int MAXW_CD = (CT_CLK_DATA > CT_CLK_CLK) ? CT_CLK_DATA : CT_CLK_CLK;
  localparam int MAXW_DD = (CT_DATA_CLK > CT_DATA_DATA) ? CT_DATA_CLK : CT_DATA_DATA;
  localparam int MAXW    = (MAXW_CD > MAXW_DD) ? MAXW_CD : MAXW_DD;
  localparam int CW      = $clog2(MAXW + 1) + 1;

  localparam logic [CW-1:0] ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

  // A window of W cycles blocks the next W-1 edges, so the counter is loaded with W-1.
  localparam logic [CW-1:0] LD_CD = (CT_CLK_DATA  > 32'sd0) ? CW'(CT_CLK_DATA  - 32'sd1) : ZERO;
  localparam logic [CW-1:0] LD_CC = (CT_CLK_CLK   > 32'sd0) ? CW'(CT_CLK_CLK   - 32'sd1) : ZERO;
  localparam logic [CW-1:0] LD_DC = (CT_DATA_CLK  > 32'sd0) ? CW'(CT_DATA_CLK  - 32'sd1) : ZERO;
  localparam logic [CW-1:0] LD_DD = (CT_DATA_DATA > 32'sd0) ? CW'(CT_DATA_DATA - 32'sd1) : ZERO;
  localparam logic          CD_ON = (CT_CLK_DATA > 32'sd0);

  function automatic logic cell_f(input logic a_seen, input logic b_seen);
    case (MODE)
      32'sd0:  cell_f = ~(a_seen ^ b_seen);
      32'sd1:  cell_f = a_seen ^ b_seen;
      32'sd2:  cell_f = a_seen & b_seen;
      default: cell_f = a_seen | b_seen;
    endcase
  endfunction

  function automatic logic [CW-1:0] cnt_dec(input logic [CW-1:0] x);
    cnt_dec = (x != ZERO) ? (x - ONE) : ZERO;
  endfunction

  function automatic logic [CW-1:0] cnt_max(input logic [CW-1:0] x, input logic [CW-1:0] y);
    cnt_max = (x > y) ? x : y;
  endfunction

  logic [CHANNELS-1:0] err_vec_s;

  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_ch
      logic             a_prev_r, b_prev_r, c_prev_r;
      logic             a_seen_r, b_seen_r;
      logic [CW-1:0]    cnt_a_r, cnt_b_r, cnt_c_r;
      logic [DELAY-1:0] pipe_r;
      logic             q_r, err_r;

      logic             a_pulse_s, b_pulse_s, c_pulse_s;
      logic             clk_ok_s, a_ok_s, b_ok_s, viol_s, fire_s;
      logic [CW-1:0]    cnt_a_clk_s, cnt_b_clk_s, cnt_c_clk_s;
      logic [CW-1:0]    cnt_a_nxt_s, cnt_b_nxt_s, cnt_c_nxt_s;
      logic             a_seen_nxt_s, b_seen_nxt_s, q_nxt_s, err_nxt_s;
      logic [DELAY-1:0] pipe_nxt_s;

      // Pulse acceptance, window arming and cell evaluation; the clock is handled before data.
      always_comb begin
        a_pulse_s = a_tgl[i] ^ a_prev_r;
        b_pulse_s = b_tgl[i] ^ b_prev_r;
        c_pulse_s = sfq_clk_tgl[i] ^ c_prev_r;

        clk_ok_s = c_pulse_s && (cnt_c_r == ZERO);
        a_ok_s   = a_pulse_s && (cnt_a_r == ZERO) && !(clk_ok_s && CD_ON);
        b_ok_s   = b_pulse_s && (cnt_b_r == ZERO) && !(clk_ok_s && CD_ON);
        viol_s   = (c_pulse_s && !clk_ok_s) || (a_pulse_s && !a_ok_s) || (b_pulse_s && !b_ok_s);
        fire_s   = clk_ok_s && cell_f(a_seen_r, b_seen_r);

        cnt_a_clk_s = clk_ok_s ? cnt_max(cnt_dec(cnt_a_r), LD_CD) : cnt_dec(cnt_a_r);
        cnt_b_clk_s = clk_ok_s ? cnt_max(cnt_dec(cnt_b_r), LD_CD) : cnt_dec(cnt_b_r);
        cnt_c_clk_s = clk_ok_s ? cnt_max(cnt_dec(cnt_c_r), LD_CC) : cnt_dec(cnt_c_r);
        cnt_a_nxt_s = a_ok_s ? cnt_max(cnt_a_clk_s, LD_DD) : cnt_a_clk_s;
        cnt_b_nxt_s = b_ok_s ? cnt_max(cnt_b_clk_s, LD_DD) : cnt_b_clk_s;
        cnt_c_nxt_s = (a_ok_s || b_ok_s) ? cnt_max(cnt_c_clk_s, LD_DC) : cnt_c_clk_s;

        a_seen_nxt_s = viol_s ? 1'b0 : ((a_seen_r && !clk_ok_s) || a_ok_s);
        b_seen_nxt_s = viol_s ? 1'b0 : ((b_seen_r && !clk_ok_s) || b_ok_s);

        // A violation cancels everything pending, including an output due this very edge.
        pipe_nxt_s    = {DELAY{1'b0}};
        pipe_nxt_s[0] = fire_s && !viol_s;
        for (int j = 1; j < DELAY; j++) begin
          pipe_nxt_s[j] = pipe_r[j-1] && !viol_s;
        end
        q_nxt_s   = q_r ^ (pipe_r[DELAY-1] && !viol_s);
        err_nxt_s = err_r | viol_s;
      end

      // Channel state; reset samples the inputs so no pulse appears right after it.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_prev_r <= a_tgl[i];
          b_prev_r <= b_tgl[i];
          c_prev_r <= sfq_clk_tgl[i];
          a_seen_r <= 1'b0;
          b_seen_r <= 1'b0;
          cnt_a_r  <= ZERO;
          cnt_b_r  <= ZERO;
          cnt_c_r  <= ZERO;
          pipe_r   <= {DELAY{1'b0}};
          q_r      <= 1'b0;
          err_r    <= 1'b0;
        end else begin
          a_prev_r <= a_tgl[i];
          b_prev_r <= b_tgl[i];
          c_prev_r <= sfq_clk_tgl[i];
          a_seen_r <= a_seen_nxt_s;
          b_seen_r <= b_seen_nxt_s;
          cnt_a_r  <= cnt_a_nxt_s;
          cnt_b_r  <= cnt_b_nxt_s;
          cnt_c_r  <= cnt_c_nxt_s;
          pipe_r   <= pipe_nxt_s;
          q_r      <= q_nxt_s;
          err_r    <= err_nxt_s;
        end
      end

      assign q_tgl[i]     = q_r;
      assign err_vec_s[i] = err_r;
    end
  endgenerate

  assign err = err_vec_s;

  // Summary flag, one cycle behind the per-channel flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_any <= 1'b0;
    end else begin
      err_any <= |err_vec_s;
    end
  end

endmodule
